// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, opcode encoding and opcode-class helpers for the reorder buffer.
package reorder_buffer_pkg;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_MUL   = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_LOAD  = 4'b0100,
        OP_STORE = 4'b0101,
        OP_BEQ   = 4'b0110,
        OP_BNEQ  = 4'b0111
    } opcode_e;

    // add/sub/mul/div/load write the register bank; 1xxx codes write nothing.
    function automatic logic writes_reg(input logic [3:0] func);
        return func <= OP_LOAD;
    endfunction

    function automatic logic is_store(input logic [3:0] func);
        return func == OP_STORE;
    endfunction

    function automatic logic is_branch(input logic [3:0] func);
        return (func == OP_BEQ) || (func == OP_BNEQ);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB / lookup / commit bundle between the pipeline and the reorder buffer.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic              alloc_valid;
    logic [3:0]        alloc_func;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_mispredict;

    logic [TAG_W-1:0]  rd_tag_a;
    logic [TAG_W-1:0]  rd_tag_b;
    logic              rd_ready_a;
    logic              rd_ready_b;
    logic [DATA_W-1:0] rd_value_a;
    logic [DATA_W-1:0] rd_value_b;

    logic              commit_valid;
    logic [TAG_W-1:0]  commit_tag;
    logic [REG_W-1:0]  commit_rd;
    logic [DATA_W-1:0] commit_value;
    logic              commit_reg_we;
    logic              commit_mem_we;
    logic              flush;
    logic [TAG_W:0]    count;

    modport master (
        output alloc_valid, alloc_func, alloc_rd,
        input  alloc_ready, alloc_tag,
        output cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
        output rd_tag_a, rd_tag_b,
        input  rd_ready_a, rd_ready_b, rd_value_a, rd_value_b,
        input  commit_valid, commit_tag, commit_rd, commit_value,
        input  commit_reg_we, commit_mem_we, flush, count
    );

    modport slave (
        input  alloc_valid, alloc_func, alloc_rd,
        output alloc_ready, alloc_tag,
        input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
        input  rd_tag_a, rd_tag_b,
        output rd_ready_a, rd_ready_b, rd_value_a, rd_value_b,
        output commit_valid, commit_tag, commit_rd, commit_value,
        output commit_reg_we, commit_mem_we, flush, count
    );

endinterface

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping ring pointer with increment and parallel load (load wins).
module reorder_buffer_rob_ptr #(
    parameter int W = 3
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer: load overrides increment; natural binary wrap at 2**W.
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tail allocation, CDB completion, head retirement, branch flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk1,
    input  logic             rst,
    reorder_buffer_if.slave  rob
);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  ready_q;
    logic [DEPTH-1:0]  mp_q;
    logic [3:0]        func_q  [DEPTH];
    logic [REG_W-1:0]  rd_q    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W-1:0]  head_inc;
    logic [TAG_W:0]    count_q;
    logic [TAG_W:0]    count_d;

    logic              alloc_fire;
    logic              commit_fire;
    logic              flush_fire;

    logic              commit_valid_q;
    logic [TAG_W-1:0]  commit_tag_q;
    logic [REG_W-1:0]  commit_rd_q;
    logic [DATA_W-1:0] commit_value_q;
    logic              commit_reg_we_q;
    logic              commit_mem_we_q;
    logic              flush_q;

    // A mispredicted branch retiring squashes everything younger, including this cycle's alloc.
    assign commit_fire = busy_q[head] & ready_q[head];
    assign flush_fire  = commit_fire & mp_q[head] & is_branch(func_q[head]);
    assign alloc_fire  = rob.alloc_valid & rob.alloc_ready & ~flush_fire;
    assign head_inc    = head + 1'b1;

    reorder_buffer_rob_ptr #(.W(TAG_W)) u_head (
        .clk1       (clk1),
        .rst        (rst),
        .inc_i      (commit_fire),
        .load_i     (1'b0),
        .load_val_i ('0),
        .ptr_o      (head)
    );

    // On flush the tail snaps to the post-retire head so the buffer reads empty.
    reorder_buffer_rob_ptr #(.W(TAG_W)) u_tail (
        .clk1       (clk1),
        .rst        (rst),
        .inc_i      (alloc_fire),
        .load_i     (flush_fire),
        .load_val_i (head_inc),
        .ptr_o      (tail)
    );

    // Entry storage: CDB completion, head retire, tail allocate (alloc applied last).
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            ready_q <= '0;
            mp_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i]  <= '0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else if (flush_fire) begin
            busy_q  <= '0;
            ready_q <= '0;
            mp_q    <= '0;
        end else begin
            if (rob.cdb_valid && busy_q[rob.cdb_tag]) begin
                ready_q[rob.cdb_tag] <= 1'b1;
                value_q[rob.cdb_tag] <= rob.cdb_value;
                mp_q[rob.cdb_tag]    <= rob.cdb_mispredict;
            end
            if (commit_fire) begin
                busy_q[head]  <= 1'b0;
                ready_q[head] <= 1'b0;
            end
            if (alloc_fire) begin
                busy_q[tail]  <= 1'b1;
                ready_q[tail] <= 1'b0;
                mp_q[tail]    <= 1'b0;
                func_q[tail]  <= rob.alloc_func;
                rd_q[tail]    <= rob.alloc_rd;
                value_q[tail] <= '0;
            end
        end
    end

    // Occupancy: +alloc -commit, cleared by a flush.
    always_comb begin
        count_d = count_q;
        if (flush_fire) begin
            count_d = '0;
        end else if (alloc_fire && !commit_fire) begin
            count_d = count_q + 1'b1;
        end else if (!alloc_fire && commit_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Registered retire port; fields are zero on cycles with no retire.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            commit_valid_q  <= 1'b0;
            commit_tag_q    <= '0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_reg_we_q <= 1'b0;
            commit_mem_we_q <= 1'b0;
            flush_q         <= 1'b0;
        end else begin
            commit_valid_q  <= commit_fire;
            flush_q         <= flush_fire;
            commit_tag_q    <= commit_fire ? head : '0;
            commit_rd_q     <= commit_fire ? rd_q[head] : '0;
            commit_value_q  <= commit_fire ? value_q[head] : '0;
            commit_reg_we_q <= commit_fire & writes_reg(func_q[head]);
            commit_mem_we_q <= commit_fire & is_store(func_q[head]);
        end
    end

    assign rob.alloc_ready   = (count_q != FULL_COUNT);
    assign rob.alloc_tag     = tail;
    assign rob.rd_ready_a    = busy_q[rob.rd_tag_a] & ready_q[rob.rd_tag_a];
    assign rob.rd_ready_b    = busy_q[rob.rd_tag_b] & ready_q[rob.rd_tag_b];
    assign rob.rd_value_a    = busy_q[rob.rd_tag_a] ? value_q[rob.rd_tag_a] : '0;
    assign rob.rd_value_b    = busy_q[rob.rd_tag_b] ? value_q[rob.rd_tag_b] : '0;
    assign rob.commit_valid  = commit_valid_q;
    assign rob.commit_tag    = commit_tag_q;
    assign rob.commit_rd     = commit_rd_q;
    assign rob.commit_value  = commit_value_q;
    assign rob.commit_reg_we = commit_reg_we_q;
    assign rob.commit_mem_we = commit_mem_we_q;
    assign rob.flush         = flush_q;
    assign rob.count         = count_q;

endmodule
